uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares the single `uarttx` transmitter between up to eight byte producers (echo path from `uartctrl`, CPU debug port, status reporters). It runs on the 16×-baud `clk` from `clkdiv`, accepts one byte per grant through a valid/ready handshake, and drives `uarttx`'s `datain`/`wrsig`. It then tracks `idle` to know when the frame has finished. It is instantiated between the requesters and `uarttx`, replacing the direct `uartctrl` → `uarttx` connection.

## Interface
- `NREQ`, default 4: number of requesters, legal range 2..8.
- `BUSY_TIMEOUT`, default 32: `clk` cycles to wait for `tx_idle` to fall after a write strobe before abandoning the transfer.

Ports (clock and reset first):
- `clk`  in  1  16×-baud clock from `clkdiv`; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  bit i set: requester i has a byte pending.
- `req_data`  in  8*NREQ  byte of requester i at [8i+7:8i].
- `req_ready`  out  NREQ  one-cycle pulse; the byte of requester i has been taken.
- `tx_data`  out  8  to `uarttx.datain`.
- `tx_wrsig`  out  1  to `uarttx.wrsig`; one-cycle pulse.
- `tx_idle`  in  1  from `uarttx.idle`; 1 = transmitter idle.
- `grant_id`  out  3  index of the last granted requester.
- `busy`  out  1  1 whenever the state is not IDLE.
- `timeout_err`  out  1  one-cycle pulse on busy timeout.

## Operation
- All outputs are registered.
- Reset values: `req_ready`=0, `tx_data`=8'h00, `tx_wrsig`=0, `grant_id`=NREQ-1, `busy`=0, `timeout_err`=0, state=IDLE, timeout counter=0, round-robin pointer=NREQ-1. With these values, requester 0 wins first after reset.
- State machine:
  - IDLE: if `tx_idle`=1 and `req_valid`≠0, select the first set bit scanning `grant_id`+1, +2, … modulo NREQ. Latch its byte into `tx_data`, set `grant_id`, and go to ISSUE. If `tx_idle`=0, stay in IDLE; this covers a frame started before reset.
  - ISSUE (one cycle): `tx_wrsig`=1 and `req_ready[grant_id]`=1. Clear the counter and go to WAIT_BUSY.
  - WAIT_BUSY: if `tx_idle`=0, go to WAIT_DONE. Otherwise increment the counter. When the counter reaches BUSY_TIMEOUT-1, pulse `timeout_err` and go to IDLE. The byte is dropped and is not retried.
  - WAIT_DONE: when `tx_idle`=1, go to IDLE.
- Requester rules:
  - Hold `req_valid` and `req_data` stable until `req_ready` is seen.
  - The byte is captured from the IDLE cycle in which the grant is made.
  - Dropping `req_valid` early is legal only while not granted.
- Requesters that are not granted see `req_ready`=0 and keep waiting; nothing is queued internally.
- Round-robin fairness: with all NREQ requesters valid continuously, each is granted exactly once per NREQ frames.
- Reset asserted mid-transfer: all state returns to reset values immediately. A frame already inside `uarttx` completes on its own, and the IDLE guard on `tx_idle` prevents overlap.
- Requests arriving in the same cycle: exactly one grant, decided by pointer order. A requester that is valid at the grant instant but not chosen is guaranteed to be served within NREQ-1 further grants.
- Timeout counter width is clog2(BUSY_TIMEOUT)+1 bits; the counter saturates and never wraps.

## Timing
- Grant latency: with `req_valid` high in cycle N, state IDLE and `tx_idle`=1, `tx_wrsig` and `req_ready` are high in cycle N+1.
- `tx_data` is valid from cycle N+1 and stays constant until the next grant.
- Minimum spacing between `tx_wrsig` pulses is one full `uarttx` frame plus 2 cycles. Back-to-back valids never produce two strobes inside one frame.
- `busy` rises in N+1 and falls the cycle after the WAIT_DONE → IDLE transition.
- `timeout_err` is high in cycle N+1+BUSY_TIMEOUT when `tx_idle` never drops.

## Test plan
- Single request: after reset, req0 is valid with 8'h41 and `tx_idle`=1. Expect in the next cycle: `tx_wrsig`=1, `req_ready`=4'b0001, `tx_data`=8'h41, `grant_id`=0. `uarttx` must shift out 'A' at 9600 baud.
- Fairness: all four requesters are valid continuously with bytes 8'h10, 8'h11, 8'h12, 8'h13. Expect grants in the order 0, 1, 2, 3, 0, 1, with exactly one `tx_wrsig` per frame.
- Busy hold-off: hold `tx_idle`=0 while req2 is valid. Expect no strobe. Release `tx_idle`. Expect a grant to req2 one cycle later.
- Timeout: model `tx_idle` stuck at 1 and assert req1 valid. Expect `timeout_err` 32 cycles after the strobe, `busy`=0 on the following cycle, and the next grant going to req2 or later, not req1.
- Reset mid-frame: assert `rst_n`=0 during WAIT_DONE. Expect all outputs at their reset values that cycle. After release, with req0 valid, expect no strobe until `tx_idle`=1.
- Late drop: req3 deasserts `req_valid` while req1 is being served. Expect req3 never to see `req_ready`, and no stray byte to be sent.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uarttx between NREQ byte producers.
// One byte per grant; the frame is tracked through tx_idle before the next grant.
module uart_tx_arbiter #(
  parameter int NREQ         = 4,
  parameter int BUSY_TIMEOUT = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [8*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]     req_ready,
  output logic [7:0]          tx_data,
  output logic                tx_wrsig,
  input  logic                tx_idle,
  output logic [2:0]          grant_id,
  output logic                busy,
  output logic                timeout_err
);
  localparam int CW = $clog2(BUSY_TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt, cnt_inc;
  logic [2:0]        start, sel;
  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot, sel_oh;
  logic [3:0]        sum;
  logic              found;
  logic [7:0]        sel_byte;

  // Rotate the request vector so bit 0 is the requester after the last grant,
  // take the lowest set bit, then map it back to an absolute index.
  always_comb begin
    start = (grant_id >= 3'(NREQ-1)) ? 3'd0 : grant_id + 3'd1;
    dbl   = {req_valid, req_valid} >> start;
    rot   = dbl[NREQ-1:0];
    found = 1'b0;
    sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, start} + 4'(k);
      end
    end
    sel      = (sum >= 4'(NREQ)) ? 3'(sum - 4'(NREQ)) : sum[2:0];
    sel_oh   = '0;
    sel_byte = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (3'(k) == sel) begin
        sel_oh[k] = 1'b1;
        sel_byte  = req_data[8*k +: 8];
      end
    end
  end

  // Saturating increment: the counter never wraps back into range.
  assign cnt_inc = (cnt == '1) ? cnt : cnt + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      req_ready   <= '0;
      tx_data     <= 8'h00;
      tx_wrsig    <= 1'b0;
      grant_id    <= 3'(NREQ-1);
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      tx_wrsig    <= 1'b0;
      req_ready   <= '0;
      timeout_err <= 1'b0;
      case (state)
        // tx_idle guard also covers a frame left running across reset
        IDLE: if (tx_idle && (|req_valid)) begin
          tx_data   <= sel_byte;
          grant_id  <= sel;
          tx_wrsig  <= 1'b1;
          req_ready <= sel_oh;
          busy      <= 1'b1;
          state     <= ISSUE;
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!tx_idle) begin
            state <= WAIT_DONE;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc == CW'(BUSY_TIMEOUT-1)) begin
              timeout_err <= 1'b1;
              busy        <= 1'b0;
              state       <= IDLE;
            end
          end
        end
        WAIT_DONE: if (tx_idle) begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus a randomized run
// checked against a transfer-level round-robin model.
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int BT   = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        tx_data;
  logic              tx_wrsig;
  logic              tx_idle;
  logic [2:0]        grant_id;
  logic              busy;
  logic              timeout_err;

  logic [7:0] dbytes [NREQ];
  logic       uart_auto = 1'b0;
  logic       force_idle = 1'b1;
  int         ucnt = 0;
  int         uframe = 6;
  int         passed = 0;
  int         total = 0;
  int         ptr;

  uart_tx_arbiter #(.NREQ(NREQ), .BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_data(tx_data), .tx_wrsig(tx_wrsig),
    .tx_idle(tx_idle), .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_data = '0;
    for (int k = 0; k < NREQ; k++) req_data[8*k +: 8] = dbytes[k];
  end

  // Transmitter stand-in: goes busy for uframe cycles after each strobe.
  always @(posedge clk) begin
    if (!uart_auto) ucnt <= 0;
    else if (tx_wrsig) ucnt <= uframe;
    else if (ucnt != 0) ucnt <= ucnt - 1;
  end
  assign tx_idle = uart_auto ? (ucnt == 0) : force_idle;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Round robin: first valid requester after the last grant, modulo NREQ.
  function automatic int model_pick(int p, logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic do_reset;
    rst_n = 1'b0; req_valid = '0; uart_auto = 1'b0; force_idle = 1'b1;
    tick; tick;
    rst_n = 1'b1;
    ptr = NREQ - 1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick;
    total++; if (req_ready !== 4'b0) $display("FAIL rst_ready: got %b expected 0000", req_ready); else passed++;
    total++; if (tx_data !== 8'h00) $display("FAIL rst_data: got %h expected 00", tx_data); else passed++;
    total++; if (tx_wrsig !== 1'b0) $display("FAIL rst_wrsig: got %b expected 0", tx_wrsig); else passed++;
    total++; if (grant_id !== 3'(NREQ-1)) $display("FAIL rst_grant: got %0d expected %0d", grant_id, NREQ-1); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else passed++;
    total++; if (timeout_err !== 1'b0) $display("FAIL rst_timeout: got %b expected 0", timeout_err); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    do_reset;
    dbytes[0] = 8'h41; req_valid = 4'b0001;
    tick;
    total++; if (tx_wrsig !== 1'b1) $display("FAIL single_wrsig: got %b expected 1", tx_wrsig); else passed++;
    total++; if (req_ready !== 4'b0001) $display("FAIL single_ready: got %b expected 0001", req_ready); else passed++;
    total++; if (tx_data !== 8'h41) $display("FAIL single_data: got %h expected 41", tx_data); else passed++;
    total++; if (grant_id !== 3'd0) $display("FAIL single_grant: got %0d expected 0", grant_id); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL single_busy: got %b expected 1", busy); else passed++;
    req_valid = '0; force_idle = 1'b0;
    tick;
    total++; if (tx_wrsig !== 1'b0 || req_ready !== 4'b0) $display("FAIL single_pulse: got wrsig %b ready %b expected 0 0000", tx_wrsig, req_ready); else passed++;
    tick; tick;
    total++; if (busy !== 1'b1) $display("FAIL single_busy_frame: got %b expected 1", busy); else passed++;
    force_idle = 1'b1;
    tick;
    total++; if (busy !== 1'b0) $display("FAIL single_busy_end: got %b expected 0", busy); else passed++;
    total++; if (tx_data !== 8'h41) $display("FAIL single_data_hold: got %h expected 41", tx_data); else passed++;
  endtask

  task automatic test_fairness;
    int cyc, last, got, exp;
    do_reset;
    for (int i = 0; i < NREQ; i++) dbytes[i] = 8'h10 + 8'(i);
    req_valid = '1; uframe = 6; uart_auto = 1'b1;
    cyc = 0; last = 0; got = 0;
    while (got < 6 && cyc < 400) begin
      tick; cyc++;
      if (tx_wrsig) begin
        exp = model_pick(ptr, '1);
        total++; if (grant_id !== 3'(exp)) $display("FAIL fair_grant: got %0d expected %0d", grant_id, exp); else passed++;
        total++; if (tx_data !== 8'h10 + 8'(exp)) $display("FAIL fair_data: got %h expected %h", tx_data, 8'h10 + 8'(exp)); else passed++;
        total++; if (req_ready !== NREQ'(1 << exp)) $display("FAIL fair_ready: got %b expected %b", req_ready, NREQ'(1 << exp)); else passed++;
        if (got > 0) begin
          total++; if (cyc - last < uframe + 2) $display("FAIL fair_spacing: got %0d expected >= %0d", cyc - last, uframe + 2); else passed++;
        end
        ptr = exp; last = cyc; got++;
      end
    end
    total++; if (got != 6) $display("FAIL fair_count: got %0d strobes expected 6", got); else passed++;
    req_valid = '0; uart_auto = 1'b0;
  endtask

  task automatic test_holdoff;
    int strobes;
    do_reset;
    force_idle = 1'b0; dbytes[2] = 8'h5a; req_valid = 4'b0100;
    strobes = 0;
    repeat (6) begin
      tick;
      if (tx_wrsig || req_ready != 4'b0) strobes++;
    end
    total++; if (strobes != 0) $display("FAIL hold_nostrobe: got %0d strobes expected 0", strobes); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL hold_busy: got %b expected 0", busy); else passed++;
    force_idle = 1'b1;
    tick;
    total++; if (tx_wrsig !== 1'b1) $display("FAIL hold_wrsig: got %b expected 1", tx_wrsig); else passed++;
    total++; if (grant_id !== 3'd2) $display("FAIL hold_grant: got %0d expected 2", grant_id); else passed++;
    total++; if (req_ready !== 4'b0100 || tx_data !== 8'h5a) $display("FAIL hold_xfer: got %b/%h expected 0100/5a", req_ready, tx_data); else passed++;
    req_valid = '0;
  endtask

  task automatic test_timeout;
    int n;
    do_reset;
    force_idle = 1'b1; dbytes[1] = 8'h77; dbytes[2] = 8'h22; req_valid = 4'b0010;
    tick;
    total++; if (tx_wrsig !== 1'b1 || grant_id !== 3'd1) $display("FAIL to_strobe: got wrsig %b grant %0d expected 1 1", tx_wrsig, grant_id); else passed++;
    req_valid = '0; n = 0;
    while (!timeout_err && n < 100) begin tick; n++; end
    total++; if (n != BT) $display("FAIL to_latency: got %0d cycles expected %0d", n, BT); else passed++;
    tick;
    total++; if (busy !== 1'b0 || timeout_err !== 1'b0) $display("FAIL to_after: got busy %b err %b expected 0 0", busy, timeout_err); else passed++;
    req_valid = 4'b0110;
    tick;
    total++; if (tx_wrsig !== 1'b1 || grant_id !== 3'd2) $display("FAIL to_next_grant: got wrsig %b grant %0d expected 1 2", tx_wrsig, grant_id); else passed++;
    total++; if (tx_data !== 8'h22) $display("FAIL to_next_data: got %h expected 22", tx_data); else passed++;
    req_valid = '0;
  endtask

  task automatic test_reset_midframe;
    int strobes;
    do_reset;
    force_idle = 1'b1; dbytes[0] = 8'h99; req_valid = 4'b0001;
    tick;
    force_idle = 1'b0;
    tick; tick; tick;
    total++; if (busy !== 1'b1) $display("FAIL mid_busy_before: got %b expected 1", busy); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || tx_wrsig !== 1'b0 || timeout_err !== 1'b0) $display("FAIL mid_rst_ctrl: got %b%b%b expected 000", busy, tx_wrsig, timeout_err); else passed++;
    total++; if (tx_data !== 8'h00 || grant_id !== 3'(NREQ-1) || req_ready !== 4'b0) $display("FAIL mid_rst_data: got %h %0d %b expected 00 %0d 0000", tx_data, grant_id, req_ready, NREQ-1); else passed++;
    tick;
    rst_n = 1'b1; strobes = 0;
    repeat (4) begin tick; if (tx_wrsig) strobes++; end
    total++; if (strobes != 0) $display("FAIL mid_nostrobe: got %0d strobes expected 0", strobes); else passed++;
    force_idle = 1'b1;
    tick;
    total++; if (tx_wrsig !== 1'b1 || grant_id !== 3'd0 || tx_data !== 8'h99) $display("FAIL mid_regrant: got %b %0d %h expected 1 0 99", tx_wrsig, grant_id, tx_data); else passed++;
    req_valid = '0;
  endtask

  task automatic test_late_drop;
    int strobes, r3;
    do_reset;
    force_idle = 1'b1; dbytes[1] = 8'h31; dbytes[3] = 8'h33; req_valid = 4'b0010;
    tick;
    total++; if (grant_id !== 3'd1 || tx_wrsig !== 1'b1) $display("FAIL late_grant1: got %0d %b expected 1 1", grant_id, tx_wrsig); else passed++;
    req_valid = 4'b1000; force_idle = 1'b0;
    strobes = 0; r3 = 0;
    tick; tick;
    req_valid = '0;
    repeat (3) begin tick; if (tx_wrsig) strobes++; if (req_ready[3]) r3++; end
    force_idle = 1'b1;
    repeat (10) begin tick; if (tx_wrsig) strobes++; if (req_ready[3]) r3++; end
    total++; if (strobes != 0) $display("FAIL late_stray: got %0d strobes expected 0", strobes); else passed++;
    total++; if (r3 != 0) $display("FAIL late_ready3: got %0d pulses expected 0", r3); else passed++;
    total++; if (tx_data !== 8'h31 || busy !== 1'b0) $display("FAIL late_state: got %h %b expected 31 0", tx_data, busy); else passed++;
  endtask

  task automatic test_random;
    logic            free, seen_low, pred, is;
    logic [NREQ-1:0] pv;
    int              exp, grants;
    do_reset;
    uframe = $urandom_range(3, 9); uart_auto = 1'b1;
    free = 1'b1; seen_low = 1'b0; pred = 1'b0; pv = '0; grants = 0;
    for (int c = 0; c < 1500; c++) begin
      tick;
      is = tx_wrsig;
      total++; if (is !== pred) $display("FAIL rnd_strobe: cycle %0d got %b expected %b", c, is, pred); else passed++;
      if (is) begin
        exp = model_pick(ptr, pv);
        total++; if (grant_id !== 3'(exp)) $display("FAIL rnd_grant: got %0d expected %0d", grant_id, exp); else passed++;
        total++; if (tx_data !== dbytes[exp]) $display("FAIL rnd_data: got %h expected %h", tx_data, dbytes[exp]); else passed++;
        total++; if (req_ready !== NREQ'(1 << exp)) $display("FAIL rnd_ready: got %b expected %b", req_ready, NREQ'(1 << exp)); else passed++;
        ptr = exp; req_valid[exp] = 1'b0; grants++;
        free = 1'b0; seen_low = 1'b0;
      end
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          dbytes[i] = 8'($urandom); req_valid[i] = 1'b1;
        end
      pred = free && tx_idle && (|req_valid);
      pv = req_valid;
      // Arbiter frees up once the transmitter has been seen busy and then idle again.
      if (!is && !free) begin
        if (!tx_idle) seen_low = 1'b1;
        else if (seen_low) free = 1'b1;
      end
    end
    total++; if (grants < 20) $display("FAIL rnd_progress: got %0d grants expected >= 20", grants); else passed++;
    req_valid = '0; uart_auto = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) dbytes[i] = 8'h00;
    tick;
    test_reset;
    test_single;
    test_fairness;
    test_holdoff;
    test_timeout;
    test_reset_midframe;
    test_late_drop;
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
